// File: rtl/alarm_unit.sv
// Alarm unit: stores an editable BCD alarm time, rings on a time match,
// supports a limited number of snoozes and drives a pulsed 500 Hz buzzer.
module alarm_unit #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk_1khz,
  input  logic       clr,
  input  logic       tick_1hz,
  input  logic [1:0] clock_hour_h,
  input  logic [3:0] clock_hour_l,
  input  logic [2:0] clock_min_h,
  input  logic [3:0] clock_min_l,
  input  logic [2:0] clock_sec_h,
  input  logic [3:0] clock_sec_l,
  input  logic       alarm_en,
  input  logic       set_mode,
  input  logic       pos_step,
  input  logic       inc,
  input  logic       stop,
  input  logic       snooze,
  output logic [1:0] alarm_hour_h,
  output logic [3:0] alarm_hour_l,
  output logic [2:0] alarm_min_h,
  output logic [3:0] alarm_min_l,
  output logic [1:0] edit_pos,
  output logic       ringing,
  output logic       snoozing,
  output logic       beep
);

  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SW = $clog2(SNOOZE_SECS + 1);
  localparam int NW = $clog2(MAX_SNOOZE + 1);

  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECS - 1);
  localparam logic [NW-1:0] SNZ_MAX   = NW'(MAX_SNOOZE);
  localparam logic [9:0]    MS_MAX    = 10'd999;

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t        state;
  logic [RW-1:0] ring_cnt;
  logic [SW-1:0] snz_cnt;
  logic [NW-1:0] snz_num;
  logic [9:0]    ms_cnt;
  logic          time_match;
  logic          beep_win;

  // Millisecond phase counter that parks at its top value until the next tick
  function automatic logic [9:0] sat_inc_ms(input logic [9:0] v);
    return (v >= MS_MAX) ? MS_MAX : v + 10'd1;
  endfunction

  // Alarm fires only on the seconds update that lands on hh:mm:00
  assign time_match = (clock_hour_h == alarm_hour_h) && (clock_hour_l == alarm_hour_l) &&
                      (clock_min_h == alarm_min_h) && (clock_min_l == alarm_min_l) &&
                      (clock_sec_h == 3'd0) && (clock_sec_l == 4'd0);

  // Three 100 ms bursts at the start of each second
  assign beep_win = (ms_cnt < 10'd100) ||
                    ((ms_cnt >= 10'd200) && (ms_cnt < 10'd300)) ||
                    ((ms_cnt >= 10'd400) && (ms_cnt < 10'd500));

  // Alarm time editing: one digit at a time, no carries between digits
  always_ff @(posedge clk_1khz or posedge clr) begin
    if (clr) begin
      alarm_hour_h <= 2'd0;
      alarm_hour_l <= 4'd7;
      alarm_min_h  <= 3'd0;
      alarm_min_l  <= 4'd0;
      edit_pos     <= 2'd0;
    end else if (set_mode) begin
      if (pos_step) edit_pos <= edit_pos + 2'd1;
      if (inc) begin
        case (edit_pos)
          2'd0: alarm_min_l <= (alarm_min_l >= 4'd9) ? 4'd0 : alarm_min_l + 4'd1;
          2'd1: alarm_min_h <= (alarm_min_h >= 3'd5) ? 3'd0 : alarm_min_h + 3'd1;
          2'd2: begin
            if (((alarm_hour_h == 2'd2) && (alarm_hour_l >= 4'd3)) || (alarm_hour_l >= 4'd9))
              alarm_hour_l <= 4'd0;
            else
              alarm_hour_l <= alarm_hour_l + 4'd1;
          end
          default: begin
            if (alarm_hour_h >= 2'd2) begin
              alarm_hour_h <= 2'd0;
            end else begin
              alarm_hour_h <= alarm_hour_h + 2'd1;
              // Entering the 20s must not leave an hour above 23
              if ((alarm_hour_h == 2'd1) && (alarm_hour_l > 4'd3)) alarm_hour_l <= 4'd0;
            end
          end
        endcase
      end
    end
  end

  // Alarm state machine with its second counters and registered indicators
  always_ff @(posedge clk_1khz or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      snz_num  <= '0;
      ringing  <= 1'b0;
      snoozing <= 1'b0;
    end else if (!alarm_en || set_mode) begin
      state    <= IDLE;
      ringing  <= 1'b0;
      snoozing <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick_1hz && time_match) begin
            state    <= RING;
            ring_cnt <= '0;
            snz_num  <= '0;
            ringing  <= 1'b1;
            snoozing <= 1'b0;
          end
        end
        RING: begin
          if (stop) begin
            state   <= IDLE;
            ringing <= 1'b0;
          end else if (snooze && (snz_num < SNZ_MAX)) begin
            state    <= SNOOZE;
            snz_num  <= snz_num + NW'(1);
            snz_cnt  <= '0;
            ringing  <= 1'b0;
            snoozing <= 1'b1;
          end else if (tick_1hz) begin
            if (ring_cnt == RING_LAST) begin
              state   <= IDLE;
              ringing <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + RW'(1);
            end
          end
        end
        SNOOZE: begin
          if (stop) begin
            state    <= IDLE;
            snoozing <= 1'b0;
          end else if (tick_1hz) begin
            if (snz_cnt == SNZ_LAST) begin
              state    <= RING;
              ring_cnt <= '0;
              ringing  <= 1'b1;
              snoozing <= 1'b0;
            end else begin
              snz_cnt <= snz_cnt + SW'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          ringing  <= 1'b0;
          snoozing <= 1'b0;
        end
      endcase
    end
  end

  // Beep phase counter and 500 Hz buzzer toggle during ring bursts
  always_ff @(posedge clk_1khz or posedge clr) begin
    if (clr) begin
      ms_cnt <= 10'd0;
      beep   <= 1'b0;
    end else begin
      ms_cnt <= tick_1hz ? 10'd0 : sat_inc_ms(ms_cnt);
      beep   <= ((state == RING) && beep_win) ? ~beep : 1'b0;
    end
  end

endmodule

// File: tb/tb_alarm_unit.sv
// Directed self-checking bench for alarm_unit.
module tb_alarm_unit;

  logic       clk_1khz = 1'b0;
  logic       clr = 1'b1;
  logic       tick_1hz = 1'b0;
  logic [1:0] clock_hour_h = 2'd0;
  logic [3:0] clock_hour_l = 4'd0;
  logic [2:0] clock_min_h = 3'd0;
  logic [3:0] clock_min_l = 4'd0;
  logic [2:0] clock_sec_h = 3'd0;
  logic [3:0] clock_sec_l = 4'd0;
  logic       alarm_en = 1'b0;
  logic       set_mode = 1'b0;
  logic       pos_step = 1'b0;
  logic       inc = 1'b0;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic [1:0] alarm_hour_h;
  logic [3:0] alarm_hour_l;
  logic [2:0] alarm_min_h;
  logic [3:0] alarm_min_l;
  logic [1:0] edit_pos;
  logic       ringing;
  logic       snoozing;
  logic       beep;

  int checks = 0;
  int errors = 0;

  alarm_unit dut (
    .clk_1khz(clk_1khz), .clr(clr), .tick_1hz(tick_1hz),
    .clock_hour_h(clock_hour_h), .clock_hour_l(clock_hour_l),
    .clock_min_h(clock_min_h), .clock_min_l(clock_min_l),
    .clock_sec_h(clock_sec_h), .clock_sec_l(clock_sec_l),
    .alarm_en(alarm_en), .set_mode(set_mode), .pos_step(pos_step), .inc(inc),
    .stop(stop), .snooze(snooze),
    .alarm_hour_h(alarm_hour_h), .alarm_hour_l(alarm_hour_l),
    .alarm_min_h(alarm_min_h), .alarm_min_l(alarm_min_l),
    .edit_pos(edit_pos), .ringing(ringing), .snoozing(snoozing), .beep(beep)
  );

  always #5 clk_1khz = ~clk_1khz;

  // Alarm time packed so that hex digits read as HHMM
  function automatic logic [15:0] alarm_time();
    return {2'b00, alarm_hour_h, alarm_hour_l, 1'b0, alarm_min_h, alarm_min_l};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_1khz);
      #1;
    end
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
  endtask

  task automatic do_pos(input int n);
    repeat (n) begin pos_step = 1'b1; cyc(1); pos_step = 1'b0; end
  endtask

  task automatic do_inc(input int n);
    repeat (n) begin inc = 1'b1; cyc(1); inc = 1'b0; end
  endtask

  task automatic do_snooze();
    snooze = 1'b1; cyc(1); snooze = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; cyc(1); stop = 1'b0;
  endtask

  // Present 07:0m:00 on a tick, then move the clock away from the match
  task automatic trigger_ring(input logic [3:0] ml);
    clock_hour_h = 2'd0; clock_hour_l = 4'd7; clock_min_h = 3'd0; clock_min_l = ml;
    clock_sec_h = 3'd0; clock_sec_l = 4'd0;
    do_tick();
    clock_min_l = ml + 4'd1;
  endtask

  initial begin
    // reset state while clr is held
    #12;
    check("rst_ringing", 16'(ringing), 16'd0);
    check("rst_snoozing", 16'(snoozing), 16'd0);
    check("rst_beep", 16'(beep), 16'd0);
    check("rst_alarm", alarm_time(), 16'h0700);
    check("rst_edit_pos", 16'(edit_pos), 16'd0);
    @(posedge clk_1khz); #1;
    clr = 1'b0;

    // editing
    do_pos(1);
    check("pos_ignored", 16'(edit_pos), 16'd0);
    set_mode = 1'b1;
    do_pos(3);
    check("pos_x3", 16'(edit_pos), 16'd3);
    do_inc(2);
    check("hour_h_guard", alarm_time(), 16'h2000);
    do_pos(3);
    check("pos_wrap", 16'(edit_pos), 16'd2);
    do_inc(3);
    check("hour_l_23", alarm_time(), 16'h2300);
    do_inc(1);
    check("hour_l_wrap3", alarm_time(), 16'h2000);
    do_pos(1);
    do_inc(1);
    check("hour_h_wrap", alarm_time(), 16'h0000);
    do_inc(1);
    do_pos(3);
    do_inc(9);
    check("hour_19", alarm_time(), 16'h1900);
    do_pos(1);
    do_inc(1);
    check("guard_19_20", alarm_time(), 16'h2000);
    do_inc(1);
    check("guard_20_00", alarm_time(), 16'h0000);
    do_pos(1);
    do_inc(9);
    check("min_l_9", alarm_time(), 16'h0009);
    do_inc(1);
    check("min_l_wrap", alarm_time(), 16'h0000);
    do_pos(1);
    do_inc(5);
    check("min_h_5", alarm_time(), 16'h0050);
    do_inc(1);
    check("min_h_wrap", alarm_time(), 16'h0000);
    set_mode = 1'b0;

    // synchronous-to-bench reset pulse restores defaults
    clr = 1'b1; cyc(1); clr = 1'b0;
    check("clr_alarm", alarm_time(), 16'h0700);
    check("clr_edit_pos", 16'(edit_pos), 16'd0);

    // no ring when seconds are nonzero or when disabled
    alarm_en = 1'b1;
    clock_hour_l = 4'd7; clock_sec_l = 4'd1;
    do_tick();
    check("no_match_sec", 16'(ringing), 16'd0);
    alarm_en = 1'b0;
    clock_sec_l = 4'd0;
    do_tick();
    check("no_match_dis", 16'(ringing), 16'd0);
    alarm_en = 1'b1;

    // match, beep pattern and ring timeout
    trigger_ring(4'd0);
    check("ring_start", 16'(ringing), 16'd1);
    for (int k = 1; k <= 300; k++) begin
      cyc(1);
      if (k <= 100 || k > 200) check("beep_on_win", 16'(beep), 16'(k % 2));
      else check("beep_gap", 16'(beep), 16'd0);
    end
    cyc(700);
    check("beep_late", 16'(beep), 16'd0);
    repeat (59) begin do_tick(); cyc(2); end
    check("ring_59", 16'(ringing), 16'd1);
    do_tick();
    check("ring_timeout", 16'(ringing), 16'd0);
    cyc(1);
    check("timeout_beep", 16'(beep), 16'd0);

    // snooze limit
    trigger_ring(4'd0);
    for (int i = 0; i < 3; i++) begin
      do_snooze();
      check("snz_enter", {14'd0, ringing, snoozing}, 16'b01);
      repeat (299) do_tick();
      check("snz_299", 16'(snoozing), 16'd1);
      do_tick();
      check("snz_return", {14'd0, ringing, snoozing}, 16'b10);
    end
    do_snooze();
    check("snz_4th_ignored", {14'd0, ringing, snoozing}, 16'b10);
    do_stop();
    check("stop_idle", {14'd0, ringing, snoozing}, 16'b00);

    // stop beats snooze; disable beats snooze
    trigger_ring(4'd0);
    stop = 1'b1; snooze = 1'b1; cyc(1); stop = 1'b0; snooze = 1'b0;
    check("stop_wins", {14'd0, ringing, snoozing}, 16'b00);
    trigger_ring(4'd0);
    do_snooze();
    check("snz_again", 16'(snoozing), 16'd1);
    alarm_en = 1'b0; cyc(1); alarm_en = 1'b1;
    check("en_drop", {14'd0, ringing, snoozing}, 16'b00);
    trigger_ring(4'd0);
    set_mode = 1'b1; cyc(1); set_mode = 1'b0;
    check("set_mode_drop", 16'(ringing), 16'd0);

    // asynchronous reset mid-ring with a non-default alarm
    set_mode = 1'b1; do_inc(1); set_mode = 1'b0;
    check("alarm_0701", alarm_time(), 16'h0701);
    trigger_ring(4'd1);
    check("ring_0701", 16'(ringing), 16'd1);
    cyc(1);
    check("beep_before_clr", 16'(beep), 16'd1);
    #2 clr = 1'b1;
    #1;
    check("aclr_ringing", 16'(ringing), 16'd0);
    check("aclr_beep", 16'(beep), 16'd0);
    check("aclr_alarm", alarm_time(), 16'h0700);
    #1 clr = 1'b0;
    cyc(2);
    check("post_clr_beep", {14'd0, ringing, beep}, 16'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
